// File: rtl/hamming_rx_deserializer_pkg.sv
// Shared definitions for the Hamming receive deserializer.
// Holds the codeword width, the receive FSM state encoding and a parity helper.
// Optional feature macro used by the design: HAMMING_RX_PARITY_EN.
package hamming_rx_deserializer_pkg;

  localparam int unsigned CODE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_DATA_ENC   = 2'd1;
  localparam logic [1:0] ST_PARITY_ENC = 2'd2;
  localparam logic [1:0] ST_STOP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_DATA   = ST_DATA_ENC,
    S_PARITY = ST_PARITY_ENC,
    S_STOP   = ST_STOP_ENC
  } rx_state_e;

  // Even-parity bit: makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [CODE_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/hamming_rx_fifo.sv
// Small codeword buffer between the deserializer and the Hamming decode stage.
// Ports: clk, rst_n (async active-low), push/wr_data write side,
//        pop/rd_data read side (rd_data is 0 when empty), full, empty.
// A push on a full buffer is accepted only when a pop happens in the same cycle.
module hamming_rx_fifo
  import hamming_rx_deserializer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CODE_W-1:0] wr_data,
  input  logic              pop,
  output logic [CODE_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_rx_deserializer.sv
// Serial receiver for 8-bit Hamming codewords, one bit per clock, LSB first.
// Frame: start(0), 8 data bits, [even parity], stop(1).
// Ports: clk, rst_n (async active-low), ser_in (idles high),
//        code_out/code_valid/code_ready buffered codeword handshake,
//        busy (frame in progress), frame_err (1-cycle reject pulse),
//        overrun (sticky, good frame dropped on full buffer).
// Macro HAMMING_RX_PARITY_EN adds the parity bit and its check.
module hamming_rx_deserializer
  import hamming_rx_deserializer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  rx_state_e             state;
  rx_state_e             state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt_d;
  logic [CODE_W-1:0]     shreg;
  logic [CODE_W-1:0]     shreg_d;
  logic                  stop_ok_c;
  logic                  frame_good_c;
  logic                  frame_bad_c;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
`ifdef HAMMING_RX_PARITY_EN
  logic                  perr;
  logic                  perr_d;
`endif

  assign busy       = (state != S_IDLE);
  assign code_valid = ~empty;
  assign pop        = code_valid & code_ready;
  assign push       = frame_good_c;

  // Frame is good only with a high stop bit (and matching parity when enabled).
`ifdef HAMMING_RX_PARITY_EN
  assign stop_ok_c = ser_in & ~perr;
`else
  assign stop_ok_c = ser_in;
`endif

  // Next-state and per-bit datapath.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    frame_good_c = 1'b0;
    frame_bad_c  = 1'b0;
`ifdef HAMMING_RX_PARITY_EN
    perr_d       = perr;
`endif
    case (state)
      S_IDLE: begin
        if (!ser_in) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        shreg_d[bit_cnt] = ser_in;
        bit_cnt_d        = bit_cnt + BIT_CNT_W'(1);
        if (bit_cnt == BIT_CNT_W'(CODE_W - 1)) begin
`ifdef HAMMING_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef HAMMING_RX_PARITY_EN
      S_PARITY: begin
        perr_d  = (ser_in != even_parity(shreg));
        state_d = S_STOP;
      end
`endif
      S_STOP: begin
        state_d = S_IDLE;
        if (stop_ok_c) begin
          frame_good_c = 1'b1;
        end else begin
          frame_bad_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef HAMMING_RX_PARITY_EN
      perr      <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      frame_err <= frame_bad_c;
      if (frame_good_c && full && !pop) begin
        overrun <= 1'b1;
      end
`ifdef HAMMING_RX_PARITY_EN
      perr      <= perr_d;
`endif
    end
  end

  hamming_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (shreg),
    .pop     (pop),
    .rd_data (code_out),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Scoreboard bench for hamming_rx_deserializer: a driver serialises frames and
// predicts the buffer contents; a negedge monitor pops and compares transfers.
// Honours HAMMING_RX_PARITY_EN the same way as the design.
module tb_hamming_rx_deserializer;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b1;
  logic       code_ready = 1'b0;
  logic [7:0] code_out;
  logic       code_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  bit         overrun_exp = 1'b0;
  int         ferr_exp = 0;
  int         ferr_seen = 0;
  bit         rand_ready = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_out = 8'h00;

  always #5 clk = ~clk;

  hamming_rx_deserializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, when handshake inputs are stable.
  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    check("valid_vs_model", 32'(code_valid), 32'(exp_q.size() != 0));
    if (!code_valid) check("empty_out_zero", 32'(code_out), 32'h0);
    if (prev_hold && code_valid) check("hold_stable", 32'(code_out), 32'(prev_out));
    if (code_valid && code_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 32'(code_valid), 32'h0);
      else check("pop_data", 32'(code_out), 32'(exp_q.pop_front()));
    end
    prev_hold = code_valid && !code_ready;
    prev_out  = code_out;
  end

  // Random consumer back-pressure.
  always @(posedge clk) begin
    #1;
    if (rand_ready) code_ready = 1'($urandom_range(0, 1));
  end

  // Drive one frame starting in the current slot; model its effect after the stop edge.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_bad,
                            input bit ready_at_stop);
    logic [10:0] bits;
    int          n;
    bit          good;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef HAMMING_RX_PARITY_EN
    bits[9]  = (^d) ^ par_bad;
    bits[10] = stop;
    n        = 11;
    good     = stop && !par_bad;
`else
    bits[9]  = stop;
    bits[10] = 1'b1;
    n        = 10;
    good     = stop;
`endif
    for (int i = 0; i < n; i++) begin
      ser_in = bits[i];
      if (i == n - 1 && ready_at_stop) code_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    ser_in = 1'b1;
    if (good) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else overrun_exp = 1'b1;
    end else begin
      ferr_exp++;
    end
    check("frame_err", 32'(frame_err), 32'(!good));
    check("overrun", 32'(overrun), 32'(overrun_exp));
    check("busy_after_stop", 32'(busy), 32'h0);
  endtask

  task automatic idle(input int n);
    ser_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    code_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain_done", 32'(code_valid), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code_valid"}, 32'(code_valid), 32'h0);
    check({tag, "_code_out"}, 32'(code_out), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Single good frame with consumer ready.
    code_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    drain();

    // Bad stop bit: one frame_err pulse, nothing buffered.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("frame_err_single", 32'(frame_err), 32'h0);
    idle(2);

    // Full buffer without consumer: third frame dropped, overrun set.
    code_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("held_head", 32'(code_out), 32'h11);
    drain();
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Reset mid-frame with a buffered entry, then a clean frame.
    code_ready = 1'b0;
    send_frame(8'h44, 1'b1, 1'b0, 1'b0);
    ser_in = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ser_in = 1'(i & 1);
      @(posedge clk);
      #1;
    end
    check("busy_mid_frame", 32'(busy), 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    overrun_exp = 1'b0;
    prev_hold = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    ser_in = 1'b1;
    rst_n  = 1'b1;
    idle(1);
    code_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    drain();

    // Full buffer, third stop edge coincides with a pop: nothing dropped.
    code_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1);
    drain();

`ifdef HAMMING_RX_PARITY_EN
    // Parity accepted, then parity mismatch rejected despite a good stop bit.
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    // Random traffic with random back-pressure and back-to-back frames.
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    rand_ready = 1'b0;
    idle(1);
    drain();

    check("frame_err_pulses", 32'(ferr_seen), 32'(ferr_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_rx_deserializer.md
HAMMING_RX_DESERIALIZER -- requirements
Module: hamming_rx_deserializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output codeword buffer entries (legal: 2 or 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ser_in  input  1  serial line; idles high.
REQ-005 SHALL have port code_out  output  8  head-of-buffer codeword, bit 0 = first received data bit.
REQ-006 SHALL have port code_valid  output  1  buffer non-empty.
REQ-007 SHALL have port code_ready  input  1  consumer (Hamming decode stage) accepts head entry.
REQ-008 SHALL have port busy  output  1  frame reception in progress (state != IDLE).
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-010 SHALL have port overrun  output  1  sticky flag; set on drop due to full buffer.

Function
REQ-011 SHALL be a 4-state FSM: IDLE, DATA, PARITY, STOP; one serial bit per clk, no oversampling.
REQ-012 IDLE: ser_in=0 sampled -> DATA with bit counter = 0; ser_in=1 -> stay IDLE.
REQ-013 DATA: each cycle shift ser_in into bit[counter], LSB first; after counter=7 -> PARITY (macro defined) else STOP.
REQ-014 STOP: ser_in=1 -> frame good; ser_in=0 -> frame_err pulse, frame discarded; both -> IDLE.
REQ-015 Good frame SHALL be written to the buffer at the STOP-cycle edge; code_valid high the next cycle (latency: start-bit cycle + 10 cycles, 11 with parity).
REQ-016 Transfer SHALL occur on any edge with code_valid=1 and code_ready=1; head advances.
REQ-017 code_out SHALL hold stable while code_valid=1 and code_ready=0.
REQ-018 Full buffer with good frame: if code_ready=1 same cycle, push and pop both occur; else frame dropped, overrun set, no frame_err.
REQ-019 Empty buffer: push and no pop only; code_out = 8'h00 when empty.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-021 A back-to-back start bit in the cycle after STOP SHALL be accepted (no idle gap required).
REQ-022 overrun SHALL clear only on reset.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, buffer empty, code_out 0, code_valid 0, busy 0, frame_err 0, overrun 0.
REQ-024 Reset mid-frame SHALL abandon the partial frame; reception restarts only on a fresh start bit after release.

Configuration
REQ-025 Macro HAMMING_RX_PARITY_EN defined: PARITY state samples one even-parity bit over the 8 data bits; mismatch -> frame_err pulse at STOP edge, frame discarded regardless of stop bit.
REQ-026 Macro undefined: PARITY state absent, DATA -> STOP directly, frame length 10 bits.

Structure
REQ-027 Shared package SHALL hold the state encoding localparams (IDLE=0, DATA=1, PARITY=2, STOP=3) and codeword width 8.
REQ-028 Buffer SHALL be a sub-module hamming_rx_fifo (DEPTH, push/pop/full/empty, data 8 bits).

Verification
REQ-029 Frame start,0xA5 LSB first,stop=1, code_ready=1 -> code_valid one cycle, code_out=8'hA5, frame_err 0.
REQ-030 Frame 0x3C with stop=0 -> frame_err single pulse, code_valid stays 0.
REQ-031 DEPTH=2, code_ready=0, frames 0x11,0x22,0x33 -> buffer holds 0x11,0x22, overrun=1; then ready=1 -> 0x11,0x22 in order.
REQ-032 Full buffer, third frame stop edge coincides with code_ready=1 -> no overrun, outputs 0x11,0x22,0x33.
REQ-033 rst_n low after 4 data bits -> all outputs 0; next full frame 0x5A received correctly.
REQ-034 HAMMING_RX_PARITY_EN: frame 0x07 with parity=1 accepted; parity=0 -> frame_err, nothing buffered.
